// File: rtl/sensor_serial_report_pkg.sv
// Shared constants for the sensor serial report block: FSM encodings and ASCII codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sensor_serial_report_pkg;

   // FSM state encodings, also exported on db_estado
   localparam logic [3:0] ST_INICIAL        = 4'd0;
   localparam logic [3:0] ST_PREPARA        = 4'd1;
   localparam logic [3:0] ST_AGUARDA_MEDIDA = 4'd2;
   localparam logic [3:0] ST_CARREGA        = 4'd3;
   localparam logic [3:0] ST_ENVIA          = 4'd4;
   localparam logic [3:0] ST_AGUARDA_TX     = 4'd5;
   localparam logic [3:0] ST_PROXIMO        = 4'd6;
   localparam logic [3:0] ST_FIM            = 4'd7;
   localparam logic [3:0] ST_ESPERA         = 4'd8;

   // ASCII characters used in a report
   localparam logic [6:0] ASCII_ZERO  = 7'h30;
   localparam logic [6:0] ASCII_QUEST = 7'h3F;
   localparam logic [6:0] ASCII_HASH  = 7'h23;

   // One BCD digit to ASCII; a non-decimal nibble or a timed-out measurement shows '?'
   function automatic logic [6:0] char_bcd(input logic [3:0] digit, input logic invalid);
      if (invalid || (digit > 4'd9)) begin
         return ASCII_QUEST;
      end
      return ASCII_ZERO + {3'b000, digit};
   endfunction

endpackage

// File: rtl/sensor_serial_report_if.sv
// Sensor/transmitter handshake bundle for the serial report controller.
// Latency: n/a (wires only).
// Backpressure: tx_partida/tx_pronto pulse pair; controller waits on tx_pronto.
interface sensor_serial_report_if #(
   parameter int N_DIGITS = 3
);
   logic                    medir;
   logic                    modo;
   logic                    medida_pronto;
   logic [4*N_DIGITS-1:0]   medida;
   logic                    tx_pronto;
   logic                    iniciar_medida;
   logic                    tx_partida;
   logic [6:0]              tx_dado;
   logic                    pronto;
   logic                    timeout;
   logic [3:0]              db_estado;

   // controller side
   modport master (
      input  medir, modo, medida_pronto, medida, tx_pronto,
      output iniciar_medida, tx_partida, tx_dado, pronto, timeout, db_estado
   );

   // sensor / transmitter / host side
   modport slave (
      output medir, modo, medida_pronto, medida, tx_pronto,
      input  iniciar_medida, tx_partida, tx_dado, pronto, timeout, db_estado
   );
endinterface

// File: rtl/sensor_serial_report_contador_m.sv
// Generic modulo-M counter with clear, enable and end-of-count flag; saturates at M-1.
// Latency: end_o is registered-count based, valid the cycle the count equals M-1.
// Backpressure: none; enable gates counting.
module contador_m #(
   parameter int M = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic end_o
);
   localparam int W = (M > 1) ? $clog2(M) : 1;
   localparam logic [W-1:0] LAST = W'(M - 1);

   logic [W-1:0] count_q, count_d;

   // Clear restarts the run; a clear cycle that is also enabled counts as the first cycle
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = (enable_i && (M > 1)) ? W'(1) : '0;
      end else if (enable_i && (count_q != LAST)) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign end_o = (count_q == LAST);
endmodule

// File: rtl/sensor_serial_report.sv
// Measures distance on request and reports it as N_DIGITS ASCII digits plus a terminator.
// Latency: iniciar_medida one cycle after medir; first tx_partida two cycles after medida_pronto.
// Backpressure: one character in flight; waits for tx_pronto before the next tx_partida.
module sensor_serial_report
   import sensor_serial_report_pkg::*;
#(
   parameter int         N_DIGITS       = 3,
   parameter logic [6:0] TERM           = ASCII_HASH,
   parameter int         TIMEOUT_CYCLES = 1_250_000,
   parameter int         PERIOD_CYCLES  = 50_000_000
) (
   input  logic                   clock,
   input  logic                   reset,
   sensor_serial_report_if.master bus
);
   localparam int             MW       = 4 * N_DIGITS;
   localparam int             IW       = $clog2(N_DIGITS + 1);
   localparam logic [IW-1:0]  LAST_IDX = IW'(N_DIGITS);

   logic [3:0]    state_q, state_d;
   logic [MW-1:0] med_q, med_d;      // latched measurement, shifted so the next digit is on top
   logic [IW-1:0] idx_q, idx_d;
   logic          timeout_q, timeout_d;
   logic [6:0]    tx_dado_q, tx_dado_d;
   logic          tmo_end, per_end;

   contador_m #(.M(TIMEOUT_CYCLES)) u_tmo (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (state_q == ST_PREPARA),
      .enable_i (state_q == ST_AGUARDA_MEDIDA),
      .end_o    (tmo_end)
   );

   // Period runs from the PREPARA cycle itself, so a report restarts exactly PERIOD_CYCLES later
   contador_m #(.M(PERIOD_CYCLES)) u_per (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (state_q == ST_PREPARA),
      .enable_i (state_q != ST_INICIAL),
      .end_o    (per_end)
   );

   // Next-state, data latch and next character selection
   always_comb begin
      state_d   = state_q;
      med_d     = med_q;
      idx_d     = idx_q;
      timeout_d = timeout_q;
      tx_dado_d = tx_dado_q;
      case (state_q)
         ST_INICIAL:        if (bus.medir) state_d = ST_PREPARA;
         ST_PREPARA:        state_d = ST_AGUARDA_MEDIDA;
         ST_AGUARDA_MEDIDA: begin
            if (bus.medida_pronto) begin
               state_d = ST_CARREGA;
            end else if (tmo_end) begin
               timeout_d = 1'b1;
               state_d   = ST_CARREGA;
            end
         end
         ST_CARREGA: begin
            med_d   = bus.medida;
            idx_d   = '0;
            state_d = ST_ENVIA;
         end
         ST_ENVIA:          state_d = ST_AGUARDA_TX;
         ST_AGUARDA_TX:     if (bus.tx_pronto) state_d = ST_PROXIMO;
         ST_PROXIMO: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_FIM;
            end else begin
               idx_d   = idx_q + IW'(1);
               med_d   = med_q << 4;
               state_d = ST_ENVIA;
            end
         end
         ST_FIM, ST_ESPERA: begin
            if (!bus.modo)    state_d = ST_INICIAL;
            else if (per_end) state_d = ST_PREPARA;
            else              state_d = ST_ESPERA;
         end
         default:           state_d = ST_INICIAL;
      endcase
      // timeout reads low from the iniciar_medida cycle onward
      if (state_d == ST_PREPARA) begin
         timeout_d = 1'b0;
      end
      // character is registered on entry to ENVIA and held until the next ENVIA
      if (state_d == ST_ENVIA) begin
         tx_dado_d = (idx_d == LAST_IDX) ? TERM : char_bcd(med_d[MW-1 -: 4], timeout_d);
      end
   end

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_INICIAL;
         med_q     <= '0;
         idx_q     <= '0;
         timeout_q <= 1'b0;
         tx_dado_q <= 7'h00;
      end else begin
         state_q   <= state_d;
         med_q     <= med_d;
         idx_q     <= idx_d;
         timeout_q <= timeout_d;
         tx_dado_q <= tx_dado_d;
      end
   end

   assign bus.iniciar_medida = (state_q == ST_PREPARA);
   assign bus.tx_partida     = (state_q == ST_ENVIA);
   assign bus.pronto         = (state_q == ST_FIM);
   assign bus.tx_dado        = tx_dado_q;
   assign bus.timeout        = timeout_q;
   assign bus.db_estado      = state_q;
endmodule

// File: tb/tb_sensor_serial_report.sv
// Bench for sensor_serial_report: timeline reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: transmitter and sensor responders with programmable delays.
module tb_sensor_serial_report;
   localparam int N      = 3;
   localparam int TOUT   = 100;
   localparam int PERIOD = 200;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   sensor_serial_report_if #(.N_DIGITS(N)) bus ();

   sensor_serial_report #(
      .N_DIGITS(N), .TERM(7'h23), .TIMEOUT_CYCLES(TOUT), .PERIOD_CYCLES(PERIOD)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   function automatic logic [14:0] dut_outs();
      return {bus.db_estado, bus.iniciar_medida, bus.tx_partida, bus.tx_dado, bus.pronto, bus.timeout};
   endfunction

   // ---------------- responders ----------------
   bit sens_en = 1'b1;
   int sens_dly = 10;
   int tx_dly = 3;

   initial begin
      bus.medida_pronto = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.iniciar_medida && sens_en) begin
            repeat (sens_dly) @(posedge clock);
            #1 bus.medida_pronto = 1'b1;
            @(posedge clock);
            #1 bus.medida_pronto = 1'b0;
         end
      end
   end

   initial begin
      bus.tx_pronto = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.tx_partida) begin
            repeat (tx_dly) @(posedge clock);
            #1 bus.tx_pronto = 1'b1;
            @(posedge clock);
            #1 bus.tx_pronto = 1'b0;
         end
      end
   end

   // ---------------- event logs ----------------
   int ncyc = 0;
   int ini_q[$];
   int pr_q[$];
   logic [6:0] chars_q[$];
   int to_rise = -1;

   always @(negedge clock) begin
      ncyc++;
      if (bus.iniciar_medida) ini_q.push_back(ncyc);
      if (bus.pronto) pr_q.push_back(ncyc);
      if (bus.tx_partida) chars_q.push_back(bus.tx_dado);
      if (bus.timeout && to_rise < 0) to_rise = ncyc;
   end

   // ---------------- reference model ----------------
   logic [3:0] exp_st = 4'd0;
   logic       exp_ini = 1'b0, exp_part = 1'b0, exp_pr = 1'b0, exp_to = 1'b0;
   logic [6:0] exp_tx = 7'h00;
   bit         mrs;
   int         m_cyc = 0;

   function automatic logic [6:0] exp_char(input logic [11:0] v, input int i, input logic to);
      int d;
      if (i == N) return 7'h23;
      d = (int'(v) >> (4 * (N - 1 - i))) % 16;
      if (to || d > 9) return 7'h3F;
      return 7'(48 + d);
   endfunction

   task automatic m_tick();
      @(posedge clock);
      m_cyc++;
      mrs = reset;
      if (mrs) begin
         exp_st = 4'd0; exp_ini = 0; exp_part = 0; exp_pr = 0; exp_to = 0; exp_tx = 7'h00;
      end
   endtask

   // One or more reports starting with the measurement request; returns to idle on reset or modo=0
   task automatic run_reports();
      int waited;
      int per_start;
      logic [11:0] lat;
      forever begin
         exp_st = 4'd1; exp_ini = 1; exp_to = 0; per_start = m_cyc;
         m_tick(); if (mrs) return;
         exp_st = 4'd2; exp_ini = 0; waited = 0;
         forever begin
            m_tick(); if (mrs) return;
            if (bus.medida_pronto) break;
            if (waited == TOUT - 1) begin exp_to = 1; break; end
            waited++;
         end
         exp_st = 4'd3;
         m_tick(); if (mrs) return;
         lat = bus.medida;
         for (int i = 0; i <= N; i++) begin
            exp_st = 4'd4; exp_part = 1; exp_tx = exp_char(lat, i, exp_to);
            m_tick(); if (mrs) return;
            exp_st = 4'd5; exp_part = 0;
            do begin
               m_tick(); if (mrs) return;
            end while (!bus.tx_pronto);
            exp_st = 4'd6;
            m_tick(); if (mrs) return;
         end
         exp_st = 4'd7; exp_pr = 1;
         m_tick(); if (mrs) return;
         exp_pr = 0;
         if (!bus.modo) return;
         if (m_cyc - per_start < PERIOD) begin
            exp_st = 4'd8;
            forever begin
               m_tick(); if (mrs) return;
               if (!bus.modo) return;
               if (m_cyc - per_start >= PERIOD) break;
            end
         end
      end
   endtask

   initial begin
      forever begin
         exp_st = 4'd0; exp_ini = 0; exp_part = 0; exp_pr = 0;
         m_tick();
         if (!mrs && bus.medir) run_reports();
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (dut_outs() !== {exp_st, exp_ini, exp_part, exp_tx, exp_pr, exp_to}) begin
            failures++;
            $display("FAIL cycle_model t=%0t got st=%0d ini=%b partida=%b dado=%h pronto=%b timeout=%b expected st=%0d ini=%b partida=%b dado=%h pronto=%b timeout=%b",
                     $time, bus.db_estado, bus.iniciar_medida, bus.tx_partida, bus.tx_dado, bus.pronto, bus.timeout,
                     exp_st, exp_ini, exp_part, exp_tx, exp_pr, exp_to);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic int log_size(input int which);
      if (which == 0) return ini_q.size();
      if (which == 1) return chars_q.size();
      return pr_q.size();
   endfunction

   task automatic wait_until(input int which, input int target, input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         @(negedge clock); #1;
         if (log_size(which) >= target) return;
      end
      chk(nm, log_size(which), target);
   endtask

   task automatic clear_logs();
      ini_q.delete(); pr_q.delete(); chars_q.delete(); to_rise = -1;
   endtask

   task automatic pulse_medir();
      @(posedge clock); #1 bus.medir = 1'b1;
      @(posedge clock); #1 bus.medir = 1'b0;
   endtask

   task automatic check_chars(input string nm, input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3);
      logic [6:0] e[4];
      e[0] = c0; e[1] = c1; e[2] = c2; e[3] = c3;
      chk({nm, "_char_count"}, chars_q.size(), 4);
      if (chars_q.size() == 4) begin
         for (int i = 0; i < 4; i++) chk($sformatf("%s_char%0d", nm, i), int'(chars_q[i]), int'(e[i]));
      end
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      bus.medir = 1'b0; bus.modo = 1'b0; bus.medida = 12'h000;
      repeat (3) @(posedge clock);
      #2 chk("reset_outputs", int'(dut_outs()), 0);
      @(posedge clock); #1 reset = 1'b0;

      // single report of 123
      bus.medida = 12'h123; sens_en = 1; sens_dly = 10; tx_dly = 3;
      clear_logs(); pulse_medir();
      wait_until(2, 1, 400, "s1_pronto_wait");
      repeat (3) @(negedge clock); #1;
      check_chars("s1", 7'h31, 7'h32, 7'h33, 7'h23);
      chk("s1_pronto_count", pr_q.size(), 1);
      chk("s1_back_to_idle", int'(bus.db_estado), 0);

      // no sensor answer: timeout path
      sens_en = 0;
      clear_logs(); pulse_medir();
      wait_until(2, 1, 500, "s2_pronto_wait");
      #1;
      chk("s2_iniciar_count", ini_q.size(), 1);
      if (ini_q.size() >= 1) chk("s2_timeout_after_wait", to_rise - (ini_q[0] + 1), TOUT);
      check_chars("s2", 7'h3F, 7'h3F, 7'h3F, 7'h23);
      chk("s2_timeout_held", int'(bus.timeout), 1);

      // non-decimal middle digit
      sens_en = 1; bus.medida = 12'h1A5;
      clear_logs(); pulse_medir();
      wait_until(2, 1, 400, "s3_pronto_wait");
      #1;
      chk("s3_timeout_cleared", int'(bus.timeout), 0);
      check_chars("s3", 7'h31, 7'h3F, 7'h35, 7'h23);

      // continuous mode, fast transmitter
      bus.modo = 1; tx_dly = 1; bus.medida = 12'h042;
      clear_logs(); pulse_medir();
      wait_until(0, 3, 1200, "s4_iniciar_wait");
      @(posedge clock); #1 bus.modo = 0;
      wait_until(2, 3, 400, "s4_pronto_wait");
      repeat (3) @(negedge clock); #1;
      chk("s4_iniciar_count", ini_q.size(), 3);
      if (ini_q.size() >= 3) begin
         chk("s4_period_gap1", ini_q[1] - ini_q[0], PERIOD);
         chk("s4_period_gap2", ini_q[2] - ini_q[1], PERIOD);
      end
      chk("s4_back_to_idle", int'(bus.db_estado), 0);

      // continuous mode, report longer than the period
      bus.modo = 1; tx_dly = 60;
      clear_logs(); pulse_medir();
      wait_until(0, 2, 1000, "s5_iniciar_wait");
      @(posedge clock); #1 bus.modo = 0;
      wait_until(2, 2, 1000, "s5_pronto_wait");
      #1;
      if (ini_q.size() >= 2 && pr_q.size() >= 1) chk("s5_prepara_after_fim", ini_q[1] - pr_q[0], 1);
      else chk("s5_log_sizes", ini_q.size() + pr_q.size(), 4);

      // reset while the second character is in flight
      bus.medida = 12'h123; tx_dly = 20;
      clear_logs(); pulse_medir();
      wait_until(1, 2, 300, "s6_second_char_wait");
      @(posedge clock); #1 reset = 1'b1;
      #2 chk("s6_reset_outputs", int'(dut_outs()), 0);
      @(posedge clock); #1 reset = 1'b0;
      repeat (40) @(negedge clock); #1;
      chk("s6_no_tx_after_reset", chars_q.size(), 2);
      chk("s6_no_restart", ini_q.size(), 1);
      chk("s6_idle", int'(bus.db_estado), 0);

      // medir held high, medida changes mid-report
      bus.medida = 12'h456; tx_dly = 3;
      clear_logs();
      @(posedge clock); #1 bus.medir = 1'b1;
      wait_until(1, 1, 300, "s7_first_char_wait");
      @(posedge clock); #1 bus.medida = 12'h789;
      wait_until(2, 1, 400, "s7_pronto_wait");
      @(posedge clock); #1 bus.medir = 1'b0;
      repeat (5) @(negedge clock); #1;
      chk("s7_single_iniciar", ini_q.size(), 1);
      check_chars("s7", 7'h34, 7'h35, 7'h36, 7'h23);
      chk("s7_idle", int'(bus.db_estado), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
